// File: rtl/benes_route_sched.sv
// rtl/benes_route_sched.sv - burst scheduler driving the Benes interconnect select matrices
// Ports:
//   CLK, RST_N                  clock, synchronous active-low reset
//   CFG_WE/CFG_WADDR/CFG_*_SEL  configuration table write port
//   CMD_VALID/CMD_READY         burst command handshake, CMD_IDX entry, CMD_LEN beats-1
//   O_MODULE_SELECT/O_SLOT_SELECT  select matrices to the interconnect pair
//   O_ISSUE/O_ISSUE_LAST        beat presented at interconnect inputs
//   O_RES_VALID/O_RES_LAST      beat arriving at interconnect outputs
//   O_BUSY                      burst running or beats still in flight
module benes_route_sched #(
    parameter int DATA_WIDTH = 256,
    parameter int PORT_NUM   = 32,
    parameter int SWITCH_NUM = PORT_NUM / 2,
    parameter int STAGE_NUM  = 2 * $clog2(PORT_NUM) - 1,
    parameter int CFG_DEPTH  = 8,
    parameter int LEN_W      = 8,
    parameter int PIPE_LAT   = 12,
    parameter int CFG_LAT    = 1
) (
    input  logic                                     CLK,
    input  logic                                     RST_N,
    input  logic                                     CFG_WE,
    input  logic [$clog2(CFG_DEPTH)-1:0]             CFG_WADDR,
    input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     CFG_MOD_SEL,
    input  logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     CFG_SLOT_SEL,
    input  logic                                     CMD_VALID,
    output logic                                     CMD_READY,
    input  logic [$clog2(CFG_DEPTH)-1:0]             CMD_IDX,
    input  logic [LEN_W-1:0]                         CMD_LEN,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     O_MODULE_SELECT,
    output logic [0:STAGE_NUM-1][0:SWITCH_NUM-1]     O_SLOT_SELECT,
    output logic                                     O_ISSUE,
    output logic                                     O_ISSUE_LAST,
    output logic                                     O_RES_VALID,
    output logic                                     O_RES_LAST,
    output logic                                     O_BUSY
);

    localparam int IDX_W  = $clog2(CFG_DEPTH);
    localparam int SCNT_W = $clog2(CFG_LAT + 1);

    if (CFG_LAT < 1 || PIPE_LAT < 2 || DATA_WIDTH < 1) begin : g_param_check
        $error("benes_route_sched: CFG_LAT must be >= 1 and PIPE_LAT >= 2");
    end

    typedef logic [0:STAGE_NUM-1][0:SWITCH_NUM-1] sel_t;
    typedef enum logic [1:0] {IDLE, DRAIN, SETUP, ISSUE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cmd_idx_q, cmd_idx_d;
    logic [IDX_W-1:0]    cur_idx_q, cur_idx_d;
    logic                cur_valid_q, cur_valid_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [SCNT_W-1:0]   setup_cnt_q, setup_cnt_d;
    logic [CFG_DEPTH-1:0] dirty_q, dirty_d;
    sel_t                mod_sel_q, mod_sel_d;
    sel_t                slot_sel_q, slot_sel_d;
    logic [PIPE_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [PIPE_LAT-1:0] pipe_l_q, pipe_l_d;

    // Configuration storage is deliberately left unreset; the dirty bits
    // force a reload before any entry is trusted after reset.
    sel_t tbl_mod_q  [CFG_DEPTH];
    sel_t tbl_slot_q [CFG_DEPTH];

    logic             load;
    logic [IDX_W-1:0] load_idx;
    logic             issue;
    logic             issue_last;
    logic             drained;

    always_ff @(posedge CLK) begin
        if (CFG_WE) begin
            tbl_mod_q[CFG_WADDR]  <= CFG_MOD_SEL;
            tbl_slot_q[CFG_WADDR] <= CFG_SLOT_SEL;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_idx_d   = cmd_idx_q;
        cur_idx_d   = cur_idx_q;
        cur_valid_d = cur_valid_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        setup_cnt_d = setup_cnt_q;
        dirty_d     = dirty_q;
        mod_sel_d   = mod_sel_q;
        slot_sel_d  = slot_sel_q;
        load        = 1'b0;
        load_idx    = cmd_idx_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        CMD_READY   = 1'b0;
        // Only the final stage may still be occupied: it leaves at this edge,
        // so new selects appear exactly when the pipe is empty.
        drained     = (pipe_v_q[PIPE_LAT-2:0] == '0);

        case (state_q)
            IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    cmd_idx_d = CMD_IDX;
                    len_d     = CMD_LEN;
                    cnt_d     = '0;
                    if (cur_valid_q && (CMD_IDX == cur_idx_q) && !dirty_q[CMD_IDX]) begin
                        state_d = ISSUE;
                    end else if (|pipe_v_q) begin
                        state_d = DRAIN;
                    end else begin
                        load        = 1'b1;
                        load_idx    = CMD_IDX;
                        setup_cnt_d = '0;
                        state_d     = SETUP;
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    load        = 1'b1;
                    setup_cnt_d = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (setup_cnt_q == SCNT_W'(CFG_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else begin
                    setup_cnt_d = setup_cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                issue      = 1'b1;
                issue_last = (cnt_q == len_q);
                if (issue_last) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            mod_sel_d          = tbl_mod_q[load_idx];
            slot_sel_d         = tbl_slot_q[load_idx];
            dirty_d[load_idx]  = 1'b0;
            cur_idx_d          = load_idx;
            cur_valid_d        = 1'b1;
        end
        // A write landing on the same edge as a load wins, so the new data
        // is picked up by the next command naming that entry.
        if (CFG_WE) begin
            dirty_d[CFG_WADDR] = 1'b1;
        end

        pipe_v_d = {pipe_v_q[PIPE_LAT-2:0], issue};
        pipe_l_d = {pipe_l_q[PIPE_LAT-2:0], issue_last};
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cmd_idx_q   <= '0;
            cur_idx_q   <= '0;
            cur_valid_q <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            setup_cnt_q <= '0;
            dirty_q     <= '1;
            mod_sel_q   <= '0;
            slot_sel_q  <= '0;
            pipe_v_q    <= '0;
            pipe_l_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_idx_q   <= cmd_idx_d;
            cur_idx_q   <= cur_idx_d;
            cur_valid_q <= cur_valid_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            setup_cnt_q <= setup_cnt_d;
            dirty_q     <= dirty_d;
            mod_sel_q   <= mod_sel_d;
            slot_sel_q  <= slot_sel_d;
            pipe_v_q    <= pipe_v_d;
            pipe_l_q    <= pipe_l_d;
        end
    end

    assign O_MODULE_SELECT = mod_sel_q;
    assign O_SLOT_SELECT   = slot_sel_q;
    assign O_ISSUE         = issue;
    assign O_ISSUE_LAST    = issue_last;
    assign O_RES_VALID     = pipe_v_q[PIPE_LAT-1];
    assign O_RES_LAST      = pipe_l_q[PIPE_LAT-1];
    assign O_BUSY          = (state_q != IDLE) || (|pipe_v_q);

endmodule

// File: doc/benes_route_sched.md
# benes_route_sched

Command-driven scheduler for the 32-port packed Benes interconnect pair (RAM→module and module→RAM networks). It holds a table of switch configurations and accepts burst commands that name a configuration and a beat count. For each burst it drives the stage/switch select matrices into the interconnect and issues one data beat per cycle on the RAM-read side. It tracks every beat through the fixed network latency and flags when results reach the far side. The block sits between the top-level HE sequencer and the interconnect.

## Interface
- DATA_WIDTH, 256, not used internally; kept for parameter-list parity with the interconnect
- PORT_NUM, 32, interconnect port count
- SWITCH_NUM, PORT_NUM/2, switches per stage
- STAGE_NUM, 2*$clog2(PORT_NUM)-1, network stages
- CFG_DEPTH, 8, configuration table entries (power of 2)
- LEN_W, 8, width of the burst length field
- PIPE_LAT, 12, cycles from O_ISSUE to the matching data at the interconnect outputs
- CFG_LAT, 1, settle cycles between loading new selects and the first beat (≥1)
- CLK  in  1  clock
- RST_N  in  1  reset; synchronous, active-low
- CFG_WE  in  1  table write strobe
- CFG_WADDR  in  $clog2(CFG_DEPTH)  table write index
- CFG_MOD_SEL  in  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  RAM→module select matrix to write
- CFG_SLOT_SEL  in  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  module→RAM select matrix to write
- CMD_VALID  in  1  burst command valid
- CMD_READY  out  1  scheduler can accept a command
- CMD_IDX  in  $clog2(CFG_DEPTH)  configuration to use
- CMD_LEN  in  LEN_W  beats minus one (0 = 1 beat)
- O_MODULE_SELECT  out  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  to interconnect I_MODULE_SELECT
- O_SLOT_SELECT  out  [0:STAGE_NUM-1][0:SWITCH_NUM-1]  to interconnect I_SLOT_SELECT
- O_ISSUE  out  1  present one beat to interconnect inputs this cycle
- O_ISSUE_LAST  out  1  final beat of the burst
- O_RES_VALID  out  1  interconnect outputs hold a scheduled beat
- O_RES_LAST  out  1  final beat of the burst at the outputs
- O_BUSY  out  1  burst in progress or beats in flight

## Operation
- Table: CFG_DEPTH entries, each holding a {mod, slot} pair, written on CFG_WE. The table is not reset. One per-entry "dirty" bit is set on each write. All dirty bits are set on reset.
- Registers: cur_idx, cur_valid, beat counter (LEN_W bits), in-flight shift register (PIPE_LAT stages of {valid, last}).
- FSM states: IDLE, DRAIN, SETUP, ISSUE.
- IDLE: CMD_READY=1. On handshake, latch CMD_IDX and CMD_LEN, then choose the next state:
  - Fast path: cur_valid && CMD_IDX==cur_idx && !dirty[CMD_IDX] → ISSUE.
  - Otherwise, beats in flight → DRAIN.
  - Otherwise → SETUP. In this case the select outputs load table[CMD_IDX] on the accepting edge, dirty[CMD_IDX] clears, and cur_idx/cur_valid update.
- DRAIN: wait until the in-flight shift register is empty. Then load the selects as above and go to SETUP. The selects never change while any beat is in flight.
- SETUP: stay CFG_LAT cycles, then go to ISSUE.
- ISSUE: O_ISSUE=1 every cycle while the counter runs from 0 to the latched length. O_ISSUE_LAST=1 on the final beat, then go to IDLE.
- CMD_READY is 0 in every state except IDLE.
- Table write to the entry currently driving the selects:
  - Outputs are unaffected.
  - That entry's dirty bit is set, so the next command naming it takes the non-fast path.
- Write and command to the same index in the same cycle: the command sees the old dirty state. The new data is used from the following command onward.
- The in-flight shift register advances every cycle in all states. O_RES_VALID/O_RES_LAST are its final stage.
- O_BUSY = (state≠IDLE) || any in-flight valid.

## Timing
- Reset (synchronous, RST_N low at an edge) forces:
  - State IDLE; all outputs 0; selects 0.
  - cur_valid=0; counter and in-flight register cleared; all dirty bits set.
  - CMD_READY=1 from the first cycle after reset.
- Reset mid-burst abandons the burst. In-flight results are discarded, so no O_RES_VALID follows.
- Handshake at edge t from IDLE with an empty pipe and a non-fast path:
  - Selects are valid from cycle t+1.
  - First O_ISSUE is at t+1+CFG_LAT.
- Fast path: first O_ISSUE at t+1.
- For every beat, O_RES_VALID is high exactly PIPE_LAT cycles after its O_ISSUE, and O_RES_LAST follows O_ISSUE_LAST the same way.
- A burst of N=CMD_LEN+1 beats holds O_ISSUE for N consecutive cycles with no bubbles.
- CMD_READY returns the cycle after O_ISSUE_LAST. Minimum command-to-command spacing on the fast path is N+1 cycles.
- Maximum burst: CMD_LEN=2^LEN_W−1 (256 beats). The counter must not wrap early.

## Test plan
- Reset, write entry 2, command idx=2 len=3 at cycle 0 → selects equal entry 2 from cycle 1; O_ISSUE cycles 2–5; O_ISSUE_LAST at 5; O_RES_VALID cycles 14–17; O_RES_LAST at 17; O_BUSY falls at 18.
- Repeat idx=2 len=0 right after CMD_READY returns → fast path: O_ISSUE the cycle after the handshake, no SETUP; result 12 cycles later.
- Command idx=5 while 3 beats of idx=2 are in flight → DRAIN; the selects stay at entry 2 until the last O_RES_VALID, change the next cycle, then SETUP 1 cycle, then issue.
- Rewrite entry 2 during an idx=2 burst → the burst completes with the old selects; the next idx=2 command takes SETUP and uses the new matrix.
- CMD_LEN=255 → exactly 256 O_ISSUE pulses, single O_ISSUE_LAST, 256 O_RES_VALID.
- RST_N low for one edge mid-ISSUE → all outputs 0 next cycle; no stray O_RES_VALID over the following PIPE_LAT cycles; the next command takes SETUP.
